// File: rtl/vote_session_ctrl.sv
// Five-voter session sequencer: timed voting window, first-press-wins latching,
// one-cycle tally, then a fixed display hold. All outputs come from registers.
module vote_session_ctrl #(
  parameter int WINDOW_CYC = 1000,
  parameter int SHOW_CYC   = 500,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [4:0]       vote_yes,
  input  logic [4:0]       vote_no,
  output logic [4:0]       comps,
  output logic [4:0]       voted,
  output logic [2:0]       yes_cnt,
  output logic             majority,
  output logic             unanimous,
  output logic [1:0]       state_o,
  output logic             result_valid,
  output logic [CNT_W-1:0] time_left
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OPEN  = 2'd1,
    S_TALLY = 2'd2,
    S_SHOW  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       comps_q, comps_d;
  logic [4:0]       voted_q, voted_d;
  logic [2:0]       yes_cnt_q, yes_cnt_d;
  logic             maj_q, maj_d;
  logic             una_q, una_d;
  logic [4:0]       new_votes;

  function automatic logic [2:0] popcnt5(input logic [4:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 5; i++) c = c + {2'b00, v[i]};
    return c;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      comps_q   <= '0;
      voted_q   <= '0;
      yes_cnt_q <= '0;
      maj_q     <= 1'b0;
      una_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      comps_q   <= comps_d;
      voted_q   <= voted_d;
      yes_cnt_q <= yes_cnt_d;
      maj_q     <= maj_d;
      una_q     <= una_d;
    end
  end

  // Early close looks at voted_d so a final press closes the window that same edge.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_OPEN;
        S_OPEN:  if (voted_d == 5'h1f || cnt_q <= CNT_W'(1)) state_d = S_TALLY;
        S_TALLY: state_d = S_SHOW;
        S_SHOW:  if (cnt_q <= CNT_W'(1)) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    comps_d   = comps_q;
    voted_d   = voted_q;
    yes_cnt_d = yes_cnt_q;
    maj_d     = maj_q;
    una_d     = una_q;
    new_votes = '0;
    if (abort) begin
      cnt_d     = '0;
      comps_d   = '0;
      voted_d   = '0;
      yes_cnt_d = '0;
      maj_d     = 1'b0;
      una_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_d     = CNT_W'(WINDOW_CYC);
            comps_d   = '0;
            voted_d   = '0;
            yes_cnt_d = '0;
            maj_d     = 1'b0;
            una_d     = 1'b0;
          end
        end
        S_OPEN: begin
          // A simultaneous yes+no press records no.
          new_votes = (vote_yes | vote_no) & ~voted_q;
          voted_d   = voted_q | new_votes;
          comps_d   = (comps_q & ~new_votes) | (new_votes & vote_yes & ~vote_no);
          cnt_d     = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
        end
        S_TALLY: begin
          yes_cnt_d = popcnt5(comps_q);
          maj_d     = (yes_cnt_d >= 3'd3);
          una_d     = (yes_cnt_d == 3'd0) || (yes_cnt_d == 3'd5);
          cnt_d     = CNT_W'(SHOW_CYC);
        end
        S_SHOW: begin
          cnt_d = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
        end
        default: cnt_d = '0;
      endcase
    end
  end

  assign state_o      = state_q;
  assign comps        = comps_q;
  assign voted        = voted_q;
  assign yes_cnt      = yes_cnt_q;
  assign majority     = maj_q;
  assign unanimous    = una_q;
  assign result_valid = (state_q == S_SHOW);
  assign time_left    = (state_q == S_OPEN || state_q == S_SHOW) ? cnt_q : '0;

endmodule

// File: doc/vote_session_ctrl.md
Name: vote_session_ctrl

Overview:
- Sequences one voting session for the five-voter panel: opens a timed window, latches each voter's first choice, then closes and tallies.
- Presents the latched yes-vector to the existing 7-segment vote-display decoder and holds it for a fixed display period.
- Sits between the debounced voter buttons and the display decoder. It is the only driver of the decoder's 5-bit input.

Parameters:
- WINDOW_CYC, 1000, voting-window length in clock cycles (≥2).
- SHOW_CYC, 500, result hold time in clock cycles (≥1).
- CNT_W, 16, width of the shared down-counter; must hold max(WINDOW_CYC, SHOW_CYC).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse: open a session.
- abort  in  1  single-cycle pulse: cancel the session and return to IDLE.
- vote_yes  in  5  per-voter yes press, bit i = voter i, already debounced and single-cycle.
- vote_no  in  5  per-voter no press, same format.
- comps  out  5  latched yes-vector to the display decoder (bit i = voter i voted yes).
- voted  out  5  bit i = voter i has cast a vote this session.
- yes_cnt  out  3  number of yes votes, 0..5.
- majority  out  1  yes_cnt ≥ 3.
- unanimous  out  1  yes_cnt == 0 or yes_cnt == 5, valid in SHOW only.
- state_o  out  2  current state: 0 IDLE, 1 OPEN, 2 TALLY, 3 SHOW.
- result_valid  out  1  high throughout SHOW.
- time_left  out  CNT_W  remaining cycles of OPEN or SHOW; 0 otherwise.

Behaviour:
- Reset (async, rst_n low): state IDLE; comps, voted, yes_cnt = 0; majority, unanimous, result_valid = 0; time_left = 0.

States:
- IDLE
  - On start: go to OPEN next cycle; clear comps and voted; load counter = WINDOW_CYC.
  - Vote presses in IDLE are ignored.
- OPEN
  - Counter decrements once per cycle.
  - Voter i with voted[i]=0 and a press this cycle: set voted[i]=1; comps[i]=vote_yes[i].
  - If vote_yes[i] and vote_no[i] are both high in the same cycle, record no (comps[i]=0, voted[i]=1).
  - Voter i with voted[i]=1: further presses are ignored (first vote is final).
  - Leave for TALLY when the counter reaches 1 (window exactly WINDOW_CYC cycles).
  - Leave early for TALLY in the cycle after voted becomes 5'b11111. Voted updates take effect the cycle they are pressed.
  - start while in OPEN is ignored.
- TALLY (exactly 1 cycle)
  - Voters who did not vote count as no; comps is unchanged.
  - yes_cnt = popcount(comps); majority and unanimous registered.
  - Load counter = SHOW_CYC; go to SHOW.
- SHOW
  - result_valid = 1; comps, yes_cnt, majority, unanimous are held stable.
  - Counter decrements; return to IDLE when it reaches 1.
  - comps, yes_cnt and flags keep their values in IDLE until the next start clears them.
  - result_valid drops on entry to IDLE.
  - start in SHOW is ignored.

Abort, from any state:
- Next state is IDLE; comps, voted, yes_cnt, majority, unanimous cleared; time_left = 0.
- abort has priority over start, votes and timer expiry in the same cycle.

Output timing:
- All outputs are registered; no combinational path from inputs to outputs.
- time_left mirrors the counter in OPEN and SHOW; it is forced to 0 in IDLE and TALLY.
- Counter arithmetic is unsigned, decrements only, and never wraps below 0.

Test Plan:
- Reset mid-OPEN: after voter 2 yes, assert rst_n=0 → all outputs 0 immediately (async), state_o=0.
- Timed session, WINDOW_CYC=8:
  - Stimulus: start; voters 0, 1, 3 vote yes, voter 4 votes no, voter 2 silent.
  - Required: exactly 8 OPEN cycles; TALLY gives comps=5'b01011, yes_cnt=3, majority=1, unanimous=0, result_valid for SHOW_CYC cycles.
- Early close:
  - Stimulus: all five vote yes by OPEN cycle 3.
  - Required: TALLY at cycle 4; yes_cnt=5, unanimous=1, time_left was nonzero at exit.
- Repeat and conflicting presses:
  - Stimulus: voter 1 yes then no; voter 2 yes+no in the same cycle.
  - Required: comps[1]=1, comps[2]=0, voted[2:1]=2'b11.
- Abort collision: abort and start, or abort and the final vote, in the same cycle → IDLE, all result outputs 0.
- No votes: start, no presses → TALLY comps=0, yes_cnt=0, majority=0, unanimous=1; start pulses during OPEN or SHOW are ignored.
